// File: rtl/rc_capture_sched_if.sv
// Result stream and pulse/failsafe lines of the RC capture scheduler.
// master = the capture block (produces results), slave = the consumer side.
interface rc_capture_sched_if #(
    parameter int CHANNELS = 4,
    parameter int SIZE     = 32
);
    localparam int CW = $clog2(CHANNELS);

    logic [CHANNELS-1:0] pulse_in;
    logic                result_valid_out;
    logic                result_ready_in;
    logic [CW-1:0]       result_chan_out;
    logic [SIZE-1:0]     result_width_out;
    logic [CHANNELS-1:0] failsafe_out;

    modport master (
        input  pulse_in,
        input  result_ready_in,
        output result_valid_out,
        output result_chan_out,
        output result_width_out,
        output failsafe_out
    );

    modport slave (
        output pulse_in,
        output result_ready_in,
        input  result_valid_out,
        input  result_chan_out,
        input  result_width_out,
        input  failsafe_out
    );
endinterface

// File: rtl/rc_capture_sched.sv
// Multi-channel RC servo pulse capture: per-channel synchronizer, high-time
// counter, range check and signal-loss watchdog, followed by a round-robin
// scheduler that offers accepted widths one at a time on a valid/ready stream.
// The interface instance must use the same CHANNELS/SIZE as this module.
module rc_capture_sched #(
    parameter int CHANNELS  = 4,
    parameter int SIZE      = 32,
    parameter int SYSCLK    = 25000000,
    parameter int MIN_WIDTH = 25000,
    parameter int MAX_WIDTH = 50000,
    parameter int TIMEOUT   = 625000
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    rc_capture_sched_if.master       bus
);
    localparam int              CW    = $clog2(CHANNELS);
    localparam logic [SIZE-1:0] MIN_W = SIZE'(MIN_WIDTH);
    localparam logic [SIZE-1:0] MAX_W = SIZE'(MAX_WIDTH);
    localparam logic [SIZE-1:0] TO_W  = SIZE'(TIMEOUT);
    localparam logic [SIZE-1:0] SAT   = '1;

    // Reject nonsensical configurations at elaboration.
    if (CHANNELS < 2 || CHANNELS > 16 || SYSCLK <= 0 || MIN_WIDTH > MAX_WIDTH) begin : g_bad_cfg
        $error("rc_capture_sched: invalid parameter set");
    end

    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] grant;
    logic [CHANNELS-1:0] failsafe;
    logic [SIZE-1:0]     hold [CHANNELS];

    // ------------------------------------------------------------------
    // Per-channel capture, range check and watchdog
    // ------------------------------------------------------------------
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic            sync1_q, sync2_q, prev_q;
        logic            rise, fall;
        logic            armed_q, armed_d;
        logic [SIZE-1:0] count_q, count_d;
        logic            acc_q, acc_d;
        logic [SIZE-1:0] accw_q;
        logic [SIZE-1:0] hold_q, hold_d;
        logic            pend_q, pend_d;
        logic [SIZE-1:0] wd_q, wd_d;
        logic            fs_q, fs_d;

        // Edge detection, width counting, range check and watchdog next state.
        // NOTE: every output gets a default first so no path leaves it unassigned and no latch is inferred.
        always_comb begin
            rise    = sync2_q & ~prev_q;
            fall    = ~sync2_q & prev_q;
            armed_d = armed_q;
            count_d = count_q;
            if (rise) begin
                count_d = SIZE'(1);
                armed_d = 1'b1;
            end else if (sync2_q && armed_q) begin
                if (count_q != SAT) count_d = count_q + SIZE'(1);
            end else if (fall && armed_q) begin
                armed_d = 1'b0;
            end

            // The range decision is registered; the accept takes effect one cycle later.
            acc_d = fall && armed_q && (count_q >= MIN_W) && (count_q <= MAX_W);

            // Newest accepted width wins; an accept outranks a coincident grant clear.
            hold_d = acc_q ? accw_q : hold_q;
            if (acc_q)         pend_d = 1'b1;
            else if (grant[i]) pend_d = 1'b0;
            else               pend_d = pend_q;

            // Accept outranks a timeout in the same cycle.
            wd_d = acc_q ? '0 : ((wd_q == SAT) ? wd_q : wd_q + SIZE'(1));
            if (acc_q)              fs_d = 1'b0;
            else if (wd_d >= TO_W)  fs_d = 1'b1;
            else                    fs_d = fs_q;
        end

        // Channel state registers; sync chain resets high so a line already high at release yields no edge.
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        // NOTE: the hold register is reset like every other flop here; it is a handful of flops, not a RAM.
        always_ff @(posedge clk_in or posedge reset_in) begin
            if (reset_in) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
                prev_q  <= 1'b1;
                armed_q <= 1'b0;
                count_q <= '0;
                acc_q   <= 1'b0;
                accw_q  <= '0;
                hold_q  <= '0;
                pend_q  <= 1'b0;
                wd_q    <= '0;
                fs_q    <= 1'b1;
            end else begin
                sync1_q <= bus.pulse_in[i];
                sync2_q <= sync1_q;
                prev_q  <= sync2_q;
                armed_q <= armed_d;
                count_q <= count_d;
                acc_q   <= acc_d;
                accw_q  <= count_q;
                hold_q  <= hold_d;
                pend_q  <= pend_d;
                wd_q    <= wd_d;
                fs_q    <= fs_d;
            end
        end

        assign pending[i]  = pend_q;
        assign hold[i]     = hold_q;
        assign failsafe[i] = fs_q;
    end

    // ------------------------------------------------------------------
    // Round-robin result scheduler
    // ------------------------------------------------------------------
    typedef enum logic {S_IDLE, S_OFFER} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   last_q, last_d;
    logic [CW-1:0]   chan_q, chan_d;
    logic [SIZE-1:0] width_q, width_d;
    logic            valid_q, valid_d;
    logic [CW-1:0]   sel, cand;
    logic            found;

    // Pick the first pending channel after the last granted one, wrapping around.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            cand = CW'((int'(last_q) + k) % CHANNELS);
            if (!found && pending[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Scheduler state and offered-result registers.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= S_IDLE;
            last_q  <= CW'(CHANNELS - 1);
            chan_q  <= '0;
            width_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            chan_q  <= chan_d;
            width_q <= width_d;
            valid_q <= valid_d;
        end
    end

    // Next state: offer whenever something is pending, return once the consumer takes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (found)                state_d = S_OFFER;
            S_OFFER: if (bus.result_ready_in)  state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
    end

    // Outputs: load the granted channel in IDLE, hold it stable until accepted in OFFER.
    always_comb begin
        grant   = '0;
        last_d  = last_q;
        chan_d  = chan_q;
        width_d = width_q;
        valid_d = valid_q;
        if (state_q == S_IDLE && found) begin
            grant[sel] = 1'b1;
            last_d     = sel;
            chan_d     = sel;
            width_d    = hold[sel];
            valid_d    = 1'b1;
        end else if (state_q == S_OFFER && bus.result_ready_in) begin
            valid_d = 1'b0;
        end
    end

    assign bus.result_valid_out = valid_q;
    assign bus.result_chan_out  = chan_q;
    assign bus.result_width_out = width_q;
    assign bus.failsafe_out     = failsafe;
endmodule

// File: doc/rc_capture_sched.md
# rc_capture_sched

Multi-channel RC servo-pulse capture controller and result scheduler. Measures the high time of `CHANNELS` independent pulse inputs and rejects out-of-range widths. Runs a per-channel signal-loss watchdog. Round-robin arbitrates the accepted measurements onto one valid/ready stream consumed by the stepper setpoint logic. All widths are counted in `clk_in` cycles; at 25 MHz a 2 ms pulse reads 50000.

## Interface
- `CHANNELS`, 4, number of pulse inputs (2..16)
- `SIZE`, 32, width/counter width in bits
- `SYSCLK`, 25000000, clock frequency in Hz (informational; defaults below derive from it)
- `MIN_WIDTH`, 25000, shortest accepted pulse in cycles (1 ms)
- `MAX_WIDTH`, 50000, longest accepted pulse in cycles (2 ms)
- `TIMEOUT`, 625000, cycles without an accepted pulse before failsafe (25 ms)
- `clk_in`  in  1  system clock; the block's single clock domain
- `reset_in`  in  1  asynchronous, active-high reset
- `pulse_in`  in  CHANNELS  raw asynchronous pulse lines, bit i = channel i
- `result_valid_out`  out  1  result offered
- `result_ready_in`  in  1  consumer accepts result
- `result_chan_out`  out  $clog2(CHANNELS)  channel of offered result
- `result_width_out`  out  SIZE  measured width in cycles
- `failsafe_out`  out  CHANNELS  bit i high = channel i has no valid signal

## Operation
- Per channel: a 2-flop synchronizer followed by a previous-value flop. All three reset to 1, so a line that is already high at reset release produces no rising edge.
- Rising edge (sync=1, prev=0): `count <= 1`, `armed <= 1`.
- While sync=1 and armed: `count` increments each cycle and saturates at 2^SIZE-1; no wrap.
- Falling edge (sync=0, prev=1) with armed=1: width = `count`, `armed <= 0`. With armed=0 the edge is ignored.
- Width accepted iff MIN_WIDTH <= width <= MAX_WIDTH, both bounds inclusive. On accept: `hold[ch] <= width`, `pending[ch] <= 1`, watchdog cleared, `failsafe_out[ch] <= 0`. On reject: the width is discarded and the watchdog is not touched.
- Overwrite rule: an accept while `pending[ch]` is already set replaces `hold[ch]`, so the newest value wins. Nothing is queued.
- Watchdog, per channel: increments every cycle and saturates. When it reaches TIMEOUT, `failsafe_out[ch] <= 1`. Failsafe stays high until the next accepted pulse. An accept and a timeout in the same cycle resolve to the accept.
- Scheduler FSM has two states, IDLE and OFFER, plus a `last` register that resets to CHANNELS-1.
  - IDLE: if any `pending` bit is set, grant the first set bit scanning from last+1 upward, modulo CHANNELS. On grant: load `result_chan_out` and `result_width_out` from `hold`, clear that `pending` bit, set `last` to the granted channel, assert valid, go to OFFER.
  - Grant coincident with a new accept on the same channel: the new value stays pending, and `hold` for the next grant takes the new value.
  - OFFER: chan, width and valid are held stable until `result_ready_in` is high. On valid&ready: deassert valid, return to IDLE. The ready value is ignored in IDLE.
- Reset, async and at any time, including mid-pulse or mid-offer:
  - `result_valid_out`=0, `result_chan_out`=0, `result_width_out`=0.
  - `failsafe_out` = all ones.
  - `pending`, `armed`, counts and watchdogs cleared.
  - FSM enters IDLE.
  - An in-flight offer is dropped.

## Timing
- Measured width = number of cycles the synchronized line is high. Against a pulse aligned to `clk_in` this is exact; for asynchronous input it is ±1.
- `pulse_in` edge to edge detection: 3 cycles. The first edge on which `pulse_in` is sampled low is cycle t: `pending` sets at t+3 and `result_valid_out` rises at t+4 when the FSM is idle with nothing else pending.
- Throughput: at most one result per 2 cycles, because OFFER returns through IDLE. This is far above the pulse rate.
- Failsafe asserts exactly TIMEOUT cycles after the last accept, or after reset release.
- Combinational paths: none from inputs to outputs.

## Test plan
- Reset release with all lines low, ready=1 -> failsafe_out=4'b1111; valid stays 0; at cycle 625000 failsafe is still 1111.
- Channel 0 high for exactly 37500 cycles, ready=1 -> valid for one cycle 4 cycles after the fall; chan=0, width=37500; failsafe_out[0]=0.
- Widths 24999, 25000, 50000, 50001 on channel 1 -> only 25000 and 50000 are offered. The rejected pulses do not clear failsafe[1].
- All four channels accept in the same cycle, ready held low for 100 cycles, then high -> order is 0,1,2,3. A following simultaneous round starts at 0 again because last=3. chan/width stay stable while ready is low.
- Two accepted pulses (30000 then 40000) on channel 2 while ready is low with channel 2 not yet granted -> a single result, width=40000.
- Assert reset_in mid-pulse and mid-offer, with pulse_in[0] high across release -> valid drops immediately. No measurement comes from the pulse straddling reset; the next full pulse is measured correctly.
